gf180mcu_fd_sc_mcu7t5v0__buf_pipe: RTL and testbench

GF180MCU_FD_SC_MCU7T5V0__BUF_PIPE -- requirements
Module: gf180mcu_fd_sc_mcu7t5v0__buf_pipe

---
 rtl/gf180mcu_fd_sc_mcu7t5v0__buf_pipe_pkg.sv | 15 +
 rtl/gf180mcu_fd_sc_mcu7t5v0__buf_pipe_ptr.sv | 31 +++
 rtl/gf180mcu_fd_sc_mcu7t5v0__buf_pipe.sv | 94 +++++++++
 tb/tb_gf180mcu_fd_sc_mcu7t5v0__buf_pipe.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__buf_pipe_pkg.sv
// Shared constants and sizing helpers for the buffered pipe FIFO.
package gf180mcu_fd_sc_mcu7t5v0__buf_pipe_pkg;

  localparam int MODE_REG = 0;
  localparam int MODE_FT  = 1;

  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__buf_pipe_ptr.sv
// Wrapping storage pointer with advance enable and synchronous active-low clear.
module gf180mcu_fd_sc_mcu7t5v0__buf_pipe_ptr
  import gf180mcu_fd_sc_mcu7t5v0__buf_pipe_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         CLK,
  input  logic                         clr_n_i,
  input  logic                         en_i,
  output logic [ptr_width(DEPTH)-1:0]  ptr_o
);

  localparam int PW = ptr_width(DEPTH);

  logic [PW-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (en_i) begin
      ptr_d = (ptr_q == PW'(DEPTH - 1)) ? '0 : ptr_q + PW'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (!clr_n_i) ptr_q <= '0;
    else          ptr_q <= ptr_d;
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__buf_pipe.sv
// Small FIFO pipe buffer: registered (MODE_REG) or fall-through (MODE_FT) output.
module gf180mcu_fd_sc_mcu7t5v0__buf_pipe
  import gf180mcu_fd_sc_mcu7t5v0__buf_pipe_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int DEPTH = 2,
  parameter int MODE  = MODE_REG
) (
`ifdef USE_POWER_PINS
  inout  wire                          VDD,
  inout  wire                          VSS,
`endif
  input  logic                         CLK,
  input  logic                         RN,
  input  logic [WIDTH-1:0]             I,
  input  logic                         IV,
  output logic                         IR,
  output logic [WIDTH-1:0]             Z,
  output logic                         ZV,
  input  logic                         ZR,
  output logic [cnt_width(DEPTH)-1:0]  CNT
);

  localparam int CW = cnt_width(DEPTH);
  localparam int PW = ptr_width(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic             empty, full, push, pop, bypass, wr_en, rd_en;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CW'(DEPTH));
  assign IR    = ~full;
  assign push  = IV & ~full;
  assign CNT   = cnt_q;

  // Stored contents are never reset; Z is gated so stale words stay hidden.
  if (MODE == MODE_FT) begin : g_ft
    assign ZV = ~empty | IV;
    assign Z  = empty ? I : mem_q[rd_ptr];
  end else begin : g_reg
    assign ZV = ~empty;
    assign Z  = empty ? '0 : mem_q[rd_ptr];
  end

  assign pop    = ZV & ZR;
  assign bypass = (MODE == MODE_FT) && empty && push && pop;
  assign wr_en  = push & ~bypass;
  assign rd_en  = pop & ~bypass;

  always_comb begin
    cnt_d = cnt_q;
    case ({wr_en, rd_en})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RN) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  always_ff @(posedge CLK) begin
    if (RN && wr_en) mem_q[wr_ptr] <= I;
  end

  gf180mcu_fd_sc_mcu7t5v0__buf_pipe_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
    .CLK     (CLK),
    .clr_n_i (RN),
    .en_i    (wr_en),
    .ptr_o   (wr_ptr)
  );

  gf180mcu_fd_sc_mcu7t5v0__buf_pipe_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
    .CLK     (CLK),
    .clr_n_i (RN),
    .en_i    (rd_en),
    .ptr_o   (rd_ptr)
  );

`ifndef FUNCTIONAL
  specify
    (CLK *> Z)   = 1;
    (CLK *> ZV)  = 1;
    (CLK *> IR)  = 1;
    (CLK *> CNT) = 1;
    if (MODE == MODE_FT) (I *> Z) = 1;
  endspecify
`endif

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__buf_pipe.sv
// Scoreboard bench: several pipe configurations driven together, checked against per-instance queues.
module tb_gf180mcu_fd_sc_mcu7t5v0__buf_pipe;
  import gf180mcu_fd_sc_mcu7t5v0__buf_pipe_pkg::*;

  localparam int NI = 6;
  localparam int CW[NI] = '{8, 8, 1, 64, 1, 64};
  localparam int CD[NI] = '{4, 4, 2, 16, 16, 2};
  localparam int CM[NI] = '{MODE_REG, MODE_FT, MODE_REG, MODE_FT, MODE_FT, MODE_REG};

  logic clk = 1'b0;
  logic rn;
  logic [NI-1:0]       iv, zr, ir, zv, pend;
  logic [NI-1:0][63:0] i_d, z_w;
  logic [NI-1:0][4:0]  cnt_w;

  logic                s_rn;
  logic [NI-1:0]       s_iv, s_zr;
  logic [NI-1:0][63:0] s_d;

  logic [63:0] q [NI][$];

  int checks;
  int errors;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int W = CW[g];
    localparam int D = CD[g];
    logic [W-1:0]             z;
    logic [$clog2(D+1)-1:0]   cnt;

    gf180mcu_fd_sc_mcu7t5v0__buf_pipe #(.WIDTH(W), .DEPTH(D), .MODE(CM[g])) u_dut (
      .CLK (clk),
      .RN  (rn),
      .I   (i_d[g][W-1:0]),
      .IV  (iv[g]),
      .IR  (ir[g]),
      .Z   (z),
      .ZV  (zv[g]),
      .ZR  (zr[g]),
      .CNT (cnt)
    );

    assign z_w[g]   = 64'(z);
    assign cnt_w[g] = 5'(cnt);
  end

  function automatic logic [63:0] msk(input int n);
    logic [63:0] one;
    one = 64'd1;
    return (CW[n] == 64) ? {64{1'b1}} : ((one << CW[n]) - one);
  endfunction

  task automatic chk(input string nm, input int n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d t=%0t got %0h expected %0h", nm, n, $time, act, exp);
    end
  endtask

  // Apply staged stimulus on the falling edge; accepted words enter the scoreboard now.
  task automatic step();
    @(negedge clk);
    rn = s_rn;
    iv = s_iv;
    zr = s_zr;
    for (int n = 0; n < NI; n++) begin
      i_d[n]  = s_d[n] & msk(n);
      pend[n] = 1'b0;
      if (s_rn && s_iv[n] && (q[n].size() < CD[n])) begin
        q[n].push_back(s_d[n] & msk(n));
        pend[n] = 1'b1;
      end
    end
  endtask

  task automatic monitor_loop();
    int          stored;
    logic        ezv;
    logic [63:0] ez;
    forever begin
      @(negedge clk);
      #4;
      if (rn !== 1'b1) begin
        for (int n = 0; n < NI; n++) q[n].delete();
      end else begin
        for (int n = 0; n < NI; n++) begin
          stored = q[n].size() - int'(pend[n]);
          chk("cnt", n, 64'(cnt_w[n]), 64'(stored));
          chk("ir", n, 64'(ir[n]), 64'(stored != CD[n]));
          ezv = (stored != 0) || ((CM[n] == MODE_FT) && iv[n]);
          chk("zv", n, 64'(zv[n]), 64'(ezv));
          if (ezv) begin
            ez = (q[n].size() > 0) ? q[n][0] : 64'd0;
            chk("z", n, z_w[n], ez);
            if (zr[n] && (q[n].size() > 0)) void'(q[n].pop_front());
          end else if (CM[n] == MODE_REG) begin
            chk("z_idle", n, z_w[n], 64'd0);
          end
        end
      end
    end
  endtask

  task automatic dstep(input bit v0, input logic [63:0] d0, input bit r0,
                       input bit v1, input logic [63:0] d1, input bit r1, input bit rst_n);
    s_rn     = rst_n;
    s_iv[0]  = v0;  s_d[0] = d0;  s_zr[0] = r0;
    s_iv[1]  = v1;  s_d[1] = d1;  s_zr[1] = r1;
    for (int n = 2; n < NI; n++) begin
      s_iv[n] = 1'($urandom_range(1));
      s_zr[n] = 1'($urandom_range(1));
      s_d[n]  = {$urandom, $urandom};
    end
    step();
  endtask

  initial begin
    int pv;
    checks = 0;
    errors = 0;
    rn   = 1'b0;
    iv   = '0;
    zr   = '0;
    i_d  = '0;
    pend = '0;
    s_rn = 1'b0;
    s_iv = '0;
    s_zr = '0;
    s_d  = '0;
    fork
      monitor_loop();
    join_none

    repeat (2) dstep(0, 0, 0, 0, 0, 0, 0);

    // Fill to full with reads stalled; inst1 bypasses 0x5A while empty.
    dstep(1, 64'h11, 0, 1, 64'h5A, 1, 1);
    dstep(1, 64'h22, 0, 0, 0, 0, 1);
    dstep(1, 64'h33, 0, 0, 0, 0, 1);
    dstep(1, 64'h44, 0, 0, 0, 0, 1);
    dstep(1, 64'h55, 0, 0, 0, 0, 1);
    repeat (5) dstep(0, 0, 1, 0, 0, 0, 1);

    // Steady push+pop at CNT=2 wraps both pointers.
    dstep(1, 64'h01, 0, 0, 0, 0, 1);
    dstep(1, 64'h02, 0, 0, 0, 0, 1);
    for (int k = 0; k < 6; k++) dstep(1, 64'hA0 + 64'(k), 1, 1, 64'hC0 + 64'(k), 1, 1);
    repeat (3) dstep(0, 0, 1, 0, 0, 1, 1);

    // Stalled output with toggling IV, then reset mid-operation at CNT=3.
    dstep(1, 64'h77, 0, 1, 64'h66, 0, 1);
    for (int k = 0; k < 5; k++) dstep(k % 2 == 1, 64'h80 + 64'(k), 0, 0, 0, 0, 1);
    dstep(1, 64'hEE, 1, 1, 64'hDD, 1, 0);
    dstep(0, 0, 0, 0, 0, 0, 1);
    dstep(0, 0, 1, 0, 0, 1, 1);

    // Random traffic with alternating fill/drain bias and one reset.
    for (int c = 0; c < 3000; c++) begin
      pv = (((c / 250) % 2) == 0) ? 80 : 30;
      s_rn = (c != 1500);
      for (int n = 0; n < NI; n++) begin
        s_iv[n] = ($urandom_range(99) < 32'(pv));
        s_zr[n] = ($urandom_range(99) < 32'(110 - pv));
        s_d[n]  = {$urandom, $urandom};
      end
      step();
    end

    s_iv = '0;
    s_zr = '0;
    step();
    @(negedge clk);
    #5;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
